reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
Parametrised successor of the 4x16 MIPS register file: 2^ADDR_W registers of WIDTH bits, two combinational read ports, one synchronous write port.
- Adds synchronous reset of all registers.
- Adds an optional same-cycle write-to-read bypass.
- Adds a per-register busy scoreboard so the pipelined MIPS decode stage can detect RAW hazards on loads and long-latency results.
- Sits between decode (read/issue) and writeback (write).

Parameters:
- WIDTH, 16, data width of each register.
- ADDR_W, 2, register address width; NUM_REGS = 2**ADDR_W (derived localparam, not overridable).
- BYPASS, 1, 1 = a write in the current cycle is forwarded to matching read ports; 0 = reads show stored value only.

Ports:
- clock  in  1  single clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears all registers and busy bits.
- rr1  in  ADDR_W  read register 1 address.
- rr2  in  ADDR_W  read register 2 address.
- wr  in  ADDR_W  write register address.
- wd  in  WIDTH  write data.
- regwrite  in  1  write enable; also clears busy bit of wr.
- rd1  out  WIDTH  read data 1.
- rd2  out  WIDTH  read data 2.
- mark_busy  in  1  issue stage: mark mark_addr busy (result pending).
- mark_addr  in  ADDR_W  register to mark busy.
- busy1  out  1  rr1 value not yet available.
- busy2  out  1  rr2 value not yet available.

Behaviour:
- Clock/reset: one clock (clock); reset is synchronous and active-high (reset).
- Register 0 is hardwired zero:
  - writes to 0 are ignored; mark_busy on 0 is ignored.
  - rdX = 0 and busyX = 0 whenever rrX = 0.
- Write: on rising clock, if regwrite and wr != 0 and not reset, regs[wr] <= wd. One-cycle write latency.
- Read: combinational.
  - rdX = (BYPASS && regwrite && wr == rrX && rrX != 0) ? wd : regs[rrX].
- Scoreboard (per register i != 0), at rising clock:
  - reset: busy[i] <= 0.
  - else if mark_busy and mark_addr == i: busy[i] <= 1. Set wins over a simultaneous clear of the same register, because the newer producer has issued.
  - else if regwrite and wr == i: busy[i] <= 0.
  - else: hold.
- Busy outputs:
  - busyX = busy[rrX] && !(BYPASS && regwrite && wr == rrX && !(mark_busy && mark_addr == rrX)).
  - The bypassed writeback resolves the hazard in the same cycle unless the register is being re-marked that cycle.
  - With BYPASS = 0, busyX = busy[rrX].
- Reset:
  - After any clock with reset = 1, all regs = 0 and all busy = 0.
  - reset overrides regwrite and mark_busy in that cycle.
  - While reset = 1, rd1, rd2, busy1 and busy2 are forced to 0 (combinational gating).
- Reset mid-operation: pending busy bits are discarded; the pipeline is assumed flushed with the same reset.
- Both read ports may address the same register, including the write target; each port is evaluated independently.
- No X propagation: every register and busy bit has a defined value after the first reset clock.

Decomposition:
- Shared package regfile_pkg: WIDTH default, ADDR_W default, NUM_REGS derivation, and the zero-register index constant.
- One natural sub-module, reg_scoreboard (NUM_REGS busy bits with set/clear priority and two lookup ports). The data array and bypass muxes stay in reg_file_sb.

Test Plan:
1. Reset then read: reset = 1 for 1 clock, then rr1 = 1, rr2 = 3 -> rd1 = 0x0000, rd2 = 0x0000, busy1 = busy2 = 0.
2. Write/read latency: regwrite = 1, wr = 2, wd = 0xBEEF for 1 clock, then rr1 = 2 -> rd1 = 0xBEEF. With BYPASS = 1, rd1 = 0xBEEF already in the write cycle; with BYPASS = 0, it shows the old value that cycle.
3. Zero register: regwrite = 1, wr = 0, wd = 0x1234; mark_busy = 1, mark_addr = 0 -> next cycle rr1 = 0 gives rd1 = 0x0000, busy1 = 0.
4. Scoreboard lifecycle: mark_busy on reg 3 -> busy1 = 1 (rr1 = 3) each cycle until writeback regwrite wr = 3, wd = 0x00A5.
   - busy1 = 0 in the writeback cycle (BYPASS = 1) with rd1 = 0x00A5.
   - busy1 stays 0 afterward.
5. Set/clear collision: reg 1 busy; same cycle regwrite wr = 1 and mark_busy mark_addr = 1 -> busy1 (rr1 = 1) = 1 in that cycle and the next; regs[1] holds the new wd.
6. Reset mid-operation: regs 1–3 written to 0x1111/0x2222/0x3333, reg 2 busy, then reset = 1 together with regwrite wr = 3 -> next cycle all reads return 0x0000 and all busy outputs are 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants for the MIPS register file with scoreboard.
//   WIDTH_DEF / ADDR_W_DEF : default data and address widths
//   num_regs()             : register count for a given address width
//   ZERO_REG               : index of the hardwired-zero register
package regfile_pkg;
  localparam int WIDTH_DEF    = 16;
  localparam int ADDR_W_DEF   = 2;
  localparam int NUM_REGS_DEF = 2 ** ADDR_W_DEF;
  localparam int ZERO_REG     = 0;

  function automatic int num_regs(input int aw);
    return 1 << aw;
  endfunction
endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy bits for RAW hazard detection.
//   clock, reset       : clock, synchronous active-high clear
//   mark_busy/mark_addr: issue marks a register as having a pending result
//   clr/clr_addr       : writeback clears the register's busy bit
//   rr1/rr2            : lookup addresses
//   busy1/busy2        : raw stored busy bits at rr1/rr2
// A set and clear of the same register in one cycle leaves it busy: the
// set belongs to a newer producer than the one writing back.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mark_busy,
  input  logic [ADDR_W-1:0] mark_addr,
  input  logic              clr,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] rr1,
  input  logic [ADDR_W-1:0] rr2,
  output logic              busy1,
  output logic              busy2
);
  localparam int NUM_REGS = num_regs(ADDR_W);

  logic [NUM_REGS-1:0] busy;

  // The zero register is only ever cleared, so its bit stays 0 after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (i != ZERO_REG) begin
          if (mark_busy && mark_addr == ADDR_W'(i))
            busy[i] <= 1'b1;
          else if (clr && clr_addr == ADDR_W'(i))
            busy[i] <= 1'b0;
        end
      end
    end
  end

  assign busy1 = busy[rr1];
  assign busy2 = busy[rr2];
endmodule

// File: rtl/reg_file_sb.sv
// Parametrised MIPS register file: two combinational read ports, one
// synchronous write port, optional write-to-read bypass, busy scoreboard.
//   clock, reset          : clock, synchronous active-high clear of all state
//   rr1, rr2 / rd1, rd2   : read addresses / read data
//   wr, wd, regwrite      : write port; regwrite also clears busy[wr]
//   mark_busy, mark_addr  : issue-side busy marking
//   busy1, busy2          : operand at rr1/rr2 not yet available
// Outputs are forced to 0 while reset is high.
module reg_file_sb
  import regfile_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int BYPASS = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rr1,
  input  logic [ADDR_W-1:0] rr2,
  input  logic [ADDR_W-1:0] wr,
  input  logic [WIDTH-1:0]  wd,
  input  logic              regwrite,
  output logic [WIDTH-1:0]  rd1,
  output logic [WIDTH-1:0]  rd2,
  input  logic              mark_busy,
  input  logic [ADDR_W-1:0] mark_addr,
  output logic              busy1,
  output logic              busy2
);
  localparam int NUM_REGS = num_regs(ADDR_W);
  localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(ZERO_REG);

  logic [NUM_REGS-1:0][WIDTH-1:0] regs;
  logic sb_busy1, sb_busy2;
  logic hit1, hit2;
  logic remark1, remark2;

  always_ff @(posedge clock) begin
    if (reset)
      regs <= '0;
    else if (regwrite && wr != ZADDR)
      regs[wr] <= wd;
  end

  reg_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
    .clock     (clock),
    .reset     (reset),
    .mark_busy (mark_busy),
    .mark_addr (mark_addr),
    .clr       (regwrite),
    .clr_addr  (wr),
    .rr1       (rr1),
    .rr2       (rr2),
    .busy1     (sb_busy1),
    .busy2     (sb_busy2)
  );

  // Same-cycle writeback forwarding; never for the zero register.
  assign hit1 = (BYPASS != 0) && regwrite && wr == rr1 && rr1 != ZADDR;
  assign hit2 = (BYPASS != 0) && regwrite && wr == rr2 && rr2 != ZADDR;

  // A forwarded writeback resolves the hazard unless a newer producer
  // re-marks the same register in this cycle.
  assign remark1 = mark_busy && mark_addr == rr1;
  assign remark2 = mark_busy && mark_addr == rr2;

  assign rd1   = reset ? '0 : (hit1 ? wd : regs[rr1]);
  assign rd2   = reset ? '0 : (hit2 ? wd : regs[rr2]);
  assign busy1 = !reset && sb_busy1 && !(hit1 && !remark1);
  assign busy2 = !reset && sb_busy2 && !(hit2 && !remark2);
endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;
  localparam int WIDTH  = 16;
  localparam int ADDR_W = 2;
  localparam int NREGS  = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] rr1, rr2, wr, mark_addr;
  logic [WIDTH-1:0]  wd;
  logic              regwrite, mark_busy;
  logic [WIDTH-1:0]  rd1, rd2, rd1_0, rd2_0;
  logic              busy1, busy2, busy1_0, busy2_0;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Abstract model: stored register values and pending-result flags.
  logic [WIDTH-1:0] m_regs [NREGS];
  bit               m_busy [NREGS];

  always #5 clock = ~clock;

  reg_file_sb #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .BYPASS(1)) dut (
    .clock(clock), .reset(reset), .rr1(rr1), .rr2(rr2), .wr(wr), .wd(wd),
    .regwrite(regwrite), .rd1(rd1), .rd2(rd2), .mark_busy(mark_busy),
    .mark_addr(mark_addr), .busy1(busy1), .busy2(busy2));

  reg_file_sb #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .BYPASS(0)) dut0 (
    .clock(clock), .reset(reset), .rr1(rr1), .rr2(rr2), .wr(wr), .wd(wd),
    .regwrite(regwrite), .rd1(rd1_0), .rd2(rd2_0), .mark_busy(mark_busy),
    .mark_addr(mark_addr), .busy1(busy1_0), .busy2(busy2_0));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] exp_rd(input bit byp, input logic [ADDR_W-1:0] rr);
    if (reset || rr == 0) return '0;
    if (byp && regwrite && wr == rr) return wd;
    return m_regs[rr];
  endfunction

  function automatic bit exp_busy(input bit byp, input logic [ADDR_W-1:0] rr);
    if (reset || rr == 0) return 1'b0;
    if (byp && regwrite && wr == rr && !(mark_busy && mark_addr == rr)) return 1'b0;
    return m_busy[rr];
  endfunction

  // Model state update: writeback clears first, then a mark re-sets, so the
  // newer producer wins on a collision.
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        m_regs[i] = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (regwrite && wr != 0) begin
        m_regs[wr] = wd;
        m_busy[wr] = 1'b0;
      end
      if (mark_busy && mark_addr != 0) m_busy[mark_addr] = 1'b1;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("rd1",     32'(rd1),     32'(exp_rd(1'b1, rr1)));
      check("rd2",     32'(rd2),     32'(exp_rd(1'b1, rr2)));
      check("busy1",   32'(busy1),   32'(exp_busy(1'b1, rr1)));
      check("busy2",   32'(busy2),   32'(exp_busy(1'b1, rr2)));
      check("rd1_nb",  32'(rd1_0),   32'(exp_rd(1'b0, rr1)));
      check("rd2_nb",  32'(rd2_0),   32'(exp_rd(1'b0, rr2)));
      check("busy1_nb",32'(busy1_0), 32'(exp_busy(1'b0, rr1)));
      check("busy2_nb",32'(busy2_0), 32'(exp_busy(1'b0, rr2)));
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    reset = 0; regwrite = 0; wr = 0; wd = '0; mark_busy = 0; mark_addr = 0;
  endtask

  initial begin
    idle();
    rr1 = 0; rr2 = 0;
    reset = 1;
    chk_en = 1'b1;
    @(negedge clock);
    check("rst_rd1_forced", 32'(rd1), 32'h0);
    step();

    // 1: reset then read
    idle(); rr1 = 1; rr2 = 3;
    @(negedge clock);
    check("t1_rd1", 32'(rd1), 32'h0000);
    check("t1_rd2", 32'(rd2), 32'h0000);
    check("t1_busy1", 32'(busy1), 32'h0);
    check("t1_busy2", 32'(busy2), 32'h0);

    // 2: write latency and bypass
    step();
    regwrite = 1; wr = 2; wd = 16'hBEEF; rr1 = 2;
    @(negedge clock);
    check("t2_byp_rd1", 32'(rd1), 32'hBEEF);
    check("t2_nobyp_rd1", 32'(rd1_0), 32'h0000);
    step(); idle();
    @(negedge clock);
    check("t2_rd1", 32'(rd1), 32'hBEEF);
    check("t2_nb_rd1", 32'(rd1_0), 32'hBEEF);

    // 3: zero register
    step();
    regwrite = 1; wr = 0; wd = 16'h1234; mark_busy = 1; mark_addr = 0; rr1 = 0;
    step(); idle();
    @(negedge clock);
    check("t3_rd1", 32'(rd1), 32'h0000);
    check("t3_busy1", 32'(busy1), 32'h0);

    // 4: scoreboard lifecycle on reg 3
    step();
    mark_busy = 1; mark_addr = 3; rr1 = 3;
    step(); idle();
    @(negedge clock);
    check("t4_busy_a", 32'(busy1), 32'h1);
    step();
    @(negedge clock);
    check("t4_busy_b", 32'(busy1), 32'h1);
    step();
    regwrite = 1; wr = 3; wd = 16'h00A5;
    @(negedge clock);
    check("t4_wb_busy1", 32'(busy1), 32'h0);
    check("t4_wb_rd1", 32'(rd1), 32'h00A5);
    check("t4_wb_nb_busy1", 32'(busy1_0), 32'h1);
    step(); idle();
    @(negedge clock);
    check("t4_after_busy1", 32'(busy1), 32'h0);
    check("t4_after_rd1", 32'(rd1), 32'h00A5);

    // 5: set/clear collision on reg 1
    step();
    mark_busy = 1; mark_addr = 1; rr1 = 1;
    step();
    regwrite = 1; wr = 1; wd = 16'h5A5A; mark_busy = 1; mark_addr = 1;
    @(negedge clock);
    check("t5_coll_busy1", 32'(busy1), 32'h1);
    step(); idle();
    @(negedge clock);
    check("t5_next_busy1", 32'(busy1), 32'h1);
    check("t5_next_rd1", 32'(rd1), 32'h5A5A);

    // 6: reset mid-operation
    step();
    regwrite = 1; wr = 1; wd = 16'h1111; step();
    wr = 2; wd = 16'h2222; step();
    wr = 3; wd = 16'h3333; step();
    idle(); mark_busy = 1; mark_addr = 2; rr1 = 2; rr2 = 3; step();
    idle();
    @(negedge clock);
    check("t6_pre_busy1", 32'(busy1), 32'h1);
    check("t6_pre_rd2", 32'(rd2), 32'h3333);
    step();
    reset = 1; regwrite = 1; wr = 3; wd = 16'hFFFF;
    @(negedge clock);
    check("t6_rst_rd2", 32'(rd2), 32'h0000);
    step(); idle();
    @(negedge clock);
    check("t6_rd1", 32'(rd1), 32'h0000);
    check("t6_rd2", 32'(rd2), 32'h0000);
    check("t6_busy1", 32'(busy1), 32'h0);
    check("t6_busy2", 32'(busy2), 32'h0);
    step();
    rr1 = 1;
    @(negedge clock);
    check("t6_rd1_r1", 32'(rd1), 32'h0000);

    // Directed sweep: mixed writes, marks and reads, checked by the model.
    for (int i = 0; i < 24; i++) begin
      step();
      regwrite  = i[0];
      wr        = ADDR_W'(i % 4);
      wd        = WIDTH'(i * 16'h1357 + 16'h0101);
      mark_busy = (i % 3) == 0;
      mark_addr = ADDR_W'((i / 2) % 4);
      rr1       = ADDR_W'((i + 1) % 4);
      rr2       = ADDR_W'(i % 4);
    end
    step(); idle();
    step();
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
